// File: rtl/mux4x1_rr_arbiter_if.sv
// Request/data bundle between four requesters and the round-robin mux arbiter.
// master = requester side, slave = arbiter side.
interface mux4x1_rr_arbiter_if;
  logic [3:0] req;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic [3:0] grant;
  logic       sel0;
  logic       sel1;
  logic       valid;
  logic       out;

  modport master (
    output req, A, B, C, D,
    input  grant, sel0, sel1, valid, out
  );

  modport slave (
    input  req, A, B, C, D,
    output grant, sel0, sel1, valid, out
  );
endinterface

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux among requesters A..D,
// with bounded bursts and same-edge handover between owners.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; grant=0000, valid=0, selects hold last value
// ST_GRANT| owner {sel0,sel1} holds the mux, cnt counts burst cycles
module mux4x1_rr_arbiter #(
  parameter int BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mux4x1_rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] CNT_MAX  = 4'(BURST - 1);

  logic [0:0] state;
  logic [3:0] grant_r;
  logic [1:0] sel_r;
  logic [3:0] cnt;
  logic [1:0] ptr;

  logic [1:0] base;
  logic [2:0] pick;
  logic       hold;

  // {found, index}: first set request after 'last', with 'last' itself scanned last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!res[2] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    base = (state == ST_GRANT) ? sel_r : ptr;
    pick = rr_pick(bus.req, base);
    hold = (state == ST_GRANT) && bus.req[sel_r] && (cnt != CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_r <= 4'b0000;
      sel_r   <= 2'b00;
      cnt     <= 4'd0;
      ptr     <= 2'd3;
    end else if (hold) begin
      cnt <= cnt + 4'd1;
    end else begin
      if (state == ST_GRANT) ptr <= sel_r;
      cnt <= 4'd0;
      if (pick[2]) begin
        state   <= ST_GRANT;
        grant_r <= 4'b0001 << pick[1:0];
        sel_r   <= pick[1:0];
      end else begin
        state   <= ST_IDLE;
        grant_r <= 4'b0000;
      end
    end
  end

  logic mux_bit;

  always_comb begin
    case (sel_r)
      2'b00:   mux_bit = bus.A;
      2'b01:   mux_bit = bus.B;
      2'b10:   mux_bit = bus.C;
      default: mux_bit = bus.D;
    endcase
  end

  assign bus.grant = grant_r;
  assign bus.sel0  = sel_r[1];
  assign bus.sel1  = sel_r[0];
  assign bus.valid = (state == ST_GRANT);
  assign bus.out   = (state == ST_GRANT) ? mux_bit : 1'b0;

endmodule

// File: doc/mux4x1_rr_arbiter.md
Name: mux4x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 bit multiplexer between four requesters, A, B, C and D.
- Each requester raises a request and presents a 1-bit data stream.
- The arbiter grants one requester at a time for a bounded burst and drives the mux selects.
- It sits directly in front of MUX4X1-style select logic and delivers the selected bit with a valid flag to the downstream consumer.

Parameters:
- BURST, 4, maximum consecutive cycles one requester may hold the grant; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D
- A  input  1  data from requester A
- B  input  1  data from requester B
- C  input  1  data from requester C
- D  input  1  data from requester D
- grant  output  4  one-hot grant, registered; all zero when idle
- sel0  output  1  mux select MSB, registered
- sel1  output  1  mux select LSB, registered
- valid  output  1  high while a grant is active, registered
- out  output  1  selected data bit (combinational from registered selects); 0 when valid=0

Behaviour:
- Select encoding, fixed as {sel0,sel1}:
  - A=00, B=01, C=10, D=11.
  - grant, sel0 and sel1 always agree.
  - out = A/B/C/D per the encoding when valid=1, else 0.
- Reset (rst=1 at a rising edge):
  - grant=0000, sel0=0, sel1=0, valid=0, burst counter=0.
  - Last-owner pointer=D, so A has the highest priority after reset.
  - Reset overrides everything, including mid-burst; the grant drops on the edge where rst is sampled high.
- State machine: IDLE, GRANT.
- IDLE:
  - If req!=0 at an edge: pick the first set bit scanning from pointer+1 modulo 4 upward.
  - Load grant/sel/valid=1, set counter=0, go to GRANT.
  - Latency: req high before edge N gives grant visible after edge N (1 cycle).
  - If req==0: stay in IDLE with outputs at their idle values.
- GRANT, with owner k, evaluated at each edge:
  - Hold: if req[k]=1 and counter<BURST-1, keep the grant and increment the counter.
  - Release: occurs if req[k]=0 or counter==BURST-1. Set pointer=k.
    - Re-arbitrate the same edge among current req, scanning from k+1 modulo 4; k itself is the last candidate.
    - If a winner exists, grant it with counter=0 and stay in GRANT (no dead cycle between owners).
    - If no winner, go to IDLE: grant=0000, valid=0, sel0/sel1 keep their last value.
  - Burst expiry with only req[k] set: k is re-granted immediately for a new burst with counter=0.
  - BURST=1: every active cycle is a fresh arbitration, giving strict per-cycle rotation.
- Fairness:
  - Any continuously asserted request is granted within 3*BURST cycles of the edge where it was first sampled.
  - No requester is granted twice while another continuously requests, except the sole-requester case.
- req changes between edges have no effect; only edge-sampled values count.
- Counter width: 4 bits; it never exceeds BURST-1.
- The arbiter never drives a one-hot violation; grant is either 0000 or exactly one bit set.

Test Plan:
- Reset/idle: assert rst for 2 cycles with req=1111.
  - Expect grant=0000, valid=0, sel0=0, sel1=0, out=0.
  - After release with req=0000, outputs remain at idle values.
- Single requester, BURST=4, req=0100, C toggling:
  - grant=0100 one cycle after req.
  - sel0=1, sel1=0, out follows C.
  - Re-granted with no gap every 4 cycles; valid continuously 1.
- Full rotation, BURST=4, req=1111 held:
  - Grant sequence A,B,C,D,A, each exactly 4 cycles.
  - {sel0,sel1} goes 00,01,10,11,00.
  - With A=1, B=0, C=1, D=1, out shows 1,0,1,1 per segment.
- Early release: B owns with counter=1, B drops req, req=1001 at that edge.
  - Next grant is D (scan from C), not A.
  - Then A after D's burst.
- Reset mid-burst: C owns at counter=2, rst pulsed for one cycle.
  - grant=0000 after that edge.
  - With req=1111 after reset, A is granted first.
- BURST=1, req=1010:
  - grant alternates 0010,1000 every cycle.
  - out alternates B, D values; valid stays 1.
